// File: rtl/extend_unit.sv
// Immediate extender: decodes the I/S/B/J immediate from instruction bits [31:7]
// and presents the sign-extended result one cycle later, holding it while idle.
module extend_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:7] instr,
    input  logic [1:0]  immsrc,
    input  logic        in_valid,
    output logic [31:0] immext,
    output logic        out_valid
);

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_e;

    logic [31:0] decoded;
    logic [31:0] immext_d, immext_q;
    logic        valid_d, valid_q;

    always_comb begin
        decoded = 32'h0000_0000;
        case (imm_fmt_e'(immsrc))
            IMM_I: decoded = {{20{instr[31]}}, instr[31:20]};
            IMM_S: decoded = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: decoded = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_J: decoded = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: decoded = 32'h0000_0000;
        endcase
    end

    // An idle cycle keeps the last immediate visible but drops out_valid.
    always_comb begin
        immext_d = immext_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            immext_d = decoded;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            immext_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
        end else begin
            immext_q <= immext_d;
            valid_q  <= valid_d;
        end
    end

    assign immext    = immext_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_extend_unit.sv
// Scoreboard bench for extend_unit: the driver pushes the expected post-edge state
// of every cycle, a monitor pops and compares it one step after each rising edge.
module tb_extend_unit;

    typedef struct packed {
        logic        valid;
        logic [31:0] imm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:7] instr;
    logic [1:0]  immsrc;
    logic        in_valid;
    logic [31:0] immext;
    logic        out_valid;

    exp_t        expQ[$];
    logic [31:0] modelImm;
    int          vectors;
    int          miscompares;

    extend_unit dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .immsrc    (immsrc),
        .in_valid  (in_valid),
        .immext    (immext),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built from signed arithmetic shifts and field masks on the full word.
    function automatic logic [31:0] refImm(input logic [31:0] ins, input logic [1:0] src);
        logic signed [31:0] s;
        logic [31:0] r;
        s = ins;
        case (src)
            2'd0: r = 32'(s >>> 20);
            2'd1: r = (32'(s >>> 25) << 5) | ((ins >> 7) & 32'h1F);
            2'd2: r = (32'(s >>> 31) << 12) | (((ins >> 7) & 32'h1) << 11)
                    | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            default: r = (32'(s >>> 31) << 20) | (((ins >> 12) & 32'hFF) << 12)
                    | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
        endcase
        return r;
    endfunction

    task automatic drive(input logic r, input logic [31:0] ins, input logic [1:0] src,
                         input logic v, input logic useFixed, input logic [31:0] fixedImm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        instr    = ins[31:7];
        immsrc   = src;
        in_valid = v;
        if (r)
            modelImm = 32'h0;
        else if (v)
            modelImm = useFixed ? fixedImm : refImm(ins, src);
        e.valid = v && !r;
        e.imm   = modelImm;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] ins,
                                 input logic [1:0] src, input logic v);
        drive(r, ins, src, v, 1'b0, 32'h0);
    endtask

    task automatic applyKnown(input logic [31:0] ins, input logic [1:0] src,
                              input logic [31:0] want);
        drive(1'b0, ins, src, 1'b1, 1'b1, want);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (out_valid !== e.valid || immext !== e.imm) begin
            miscompares++;
            $display("[TB] FAIL cycle-compare @%0t: got valid=%b immext=%h, expected valid=%b immext=%h",
                     $time, out_valid, immext, e.valid, e.imm);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] ins;
        vectors     = 0;
        miscompares = 0;
        modelImm    = 32'h0;
        rst         = 1'b1;
        instr       = '0;
        immsrc      = 2'b00;
        in_valid    = 1'b0;

        applyStimulus(1'b1, 32'hFFC4A303, 2'b00, 1'b1);
        applyStimulus(1'b1, 32'h0, 2'b00, 1'b0);

        // Directed vectors with hand-derived expected values, back to back.
        applyKnown(32'hFFC4A303, 2'b00, 32'hFFFFFFFC);
        applyKnown(32'hFFC4A303, 2'b01, 32'hFFFFFFE6);
        applyKnown(32'hFFC4A303, 2'b10, 32'hFFFFF7E6);
        applyKnown(32'hFFC4A303, 2'b11, 32'hFFF4A7FC);
        applyKnown(32'h7FF00013, 2'b00, 32'h000007FF);

        repeat (3) applyStimulus(1'b0, $urandom, 2'($urandom_range(0, 3)), 1'b0);

        applyStimulus(1'b0, 32'h8000_0000, 2'b11, 1'b1);
        applyStimulus(1'b1, 32'hFFC4A303, 2'b00, 1'b1);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
        applyKnown(32'hFFC4A303, 2'b10, 32'hFFFFF7E6);

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            applyStimulus(($urandom_range(0, 31) == 0), ins, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0));
        end

        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
